i2c_receiver: RTL and testbench
===============================

# i2c_receiver

Byte-level I2C target (receiver) that samples an externally driven SCL/SDA pair, detects START/STOP, shifts in bytes MSB-first and acknowledges them by pulling SDA low on the 9th clock. It is the far end of the board I2C link and presents each received byte to fabric logic as an 8-bit word plus a one-cycle strobe. An optional 7-bit address filter lets it share a bus with other targets.

## Interface

Parameters:
- ADDR_EN, 0: 0 = every byte after START is data; 1 = first byte after START is address + R/W.
- ADDRESS, 7'h50: own 7-bit target address, used only when ADDR_EN = 1.
- ACK_EN, 1: 1 = drive ACK on accepted bytes; 0 = never drive SDA (listen-only).

Ports:
- clk  input  1  system clock; must run at ≥ 8× SCL frequency.
- rst  input  1  synchronous, active-high reset.
- SCL  input  1  bus clock from the initiator.
- SDA  inout  1  open-drain data; driven 1'b0 only during ACK, otherwise 1'bz.
- readWord  output  8  last accepted data byte.
- byteReceived  output  1  one-cycle strobe; readWord is valid in the same cycle.
- busy  output  1  high from START detection until STOP detection.
- startDetected  output  1  one-cycle pulse per START or repeated START.
- stopDetected  output  1  one-cycle pulse per STOP.

## Operation

- Input conditioning: SCL and SDA each pass through a 2-flop synchronizer. A third register holds the previous synchronized value. Edge and condition detection uses the synchronized and delayed values only.
  - sclRise = SCL rising edge; sclFall = SCL falling edge.
  - START = synchronized SDA falls while synchronized SCL is high.
  - STOP = synchronized SDA rises while synchronized SCL is high.
- States: IDLE, ADDR, DATA, ACK, IGNORE.
- IDLE: SDA released. On START, go to ADDR if ADDR_EN = 1, otherwise DATA. Clear the bit counter and assert busy.
- ADDR / DATA: on each sclRise, shift synchronized SDA into the LSB of the shift register and increment the 3-bit bit counter.
  - On the 8th sclRise in DATA: load readWord, pulse byteReceived, go to ACK.
  - On the 8th sclRise in ADDR: compare bits [7:1] with ADDRESS and require bit 0 = 0. On a match, go to ACK; the address byte is never strobed. On a mismatch, go to IGNORE with a NACK (SDA stays released).
- ACK:
  - On the first sclFall, drive SDA low if ACK_EN = 1.
  - On the second sclFall (end of the 9th clock), release SDA, clear the bit counter and return to DATA.
- IGNORE: SDA released; every SCL edge is ignored until the next START or STOP.
- START in any state: abort any partial byte, release SDA, clear the bit counter, pulse startDetected, and re-enter ADDR or DATA. Repeated START is handled identically.
- STOP in any state: discard any partial byte without a strobe, release SDA, pulse stopDetected, clear busy, go to IDLE.
- Priority: START and STOP take precedence over sclRise and sclFall evaluated in the same cycle.
- Reset, including mid-byte or mid-ACK: state = IDLE, SDA released, readWord = 8'h00, byteReceived = 0, busy = 0, startDetected = 0, stopDetected = 0, bit counter = 0.

## Timing

- A pin change first sampled at clk edge n registers its action at edge n+2. The resulting outputs are visible after edge n+2, high for exactly one cycle where they are pulses.
- byteReceived rises 2 clk cycles after the 8th SCL rise is first sampled. readWord holds that value until the next accepted byte.
- The ACK low is driven from 2 clk cycles after the 8th-bit SCL fall until 2 clk cycles after the 9th-bit SCL fall. This covers the full SCL-high phase of the 9th clock.
- Each SCL high and low phase must last ≥ 2 clk cycles; shorter phases are out of specification.
- SDA must change only while SCL is low, except for START and STOP.

## Test plan

- ADDR_EN = 0: START, bytes 8'hA5 then 8'h3C, STOP.
  - Required: byteReceived pulses twice; readWord = A5 then 3C.
  - Required: SDA reads 0 throughout each 9th SCL-high phase.
  - Required: startDetected and stopDetected each pulse once; busy is high only between them.
- ADDR_EN = 1, ADDRESS = 7'h50: address byte 8'hA0 then data 8'h12.
  - Required: ACK on both bytes; a single strobe with readWord = 12.
- ADDR_EN = 1, address byte 8'hA2 then data 8'h77.
  - Required: SDA never driven, no byteReceived, and readWord stays at its prior value.
- Repeated START after 4 data bits, then a full byte 8'hF0.
  - Required: the partial byte is discarded; one strobe with readWord = F0.
- STOP after 5 bits: no strobe, busy falls, state is IDLE. Separately, assert rst during the ACK low: SDA is released on the next clk and all outputs equal their reset values.

Source files
------------

// File: rtl/i2c_receiver.sv
// rtl/i2c_receiver.sv - I2C byte receiver: START/STOP detection, MSB-first shift, optional address filter, ACK drive
`timescale 1ns/1ps
module i2c_receiver #(
    parameter bit         ADDR_EN = 1'b0,
    parameter logic [6:0] ADDRESS = 7'h50,
    parameter bit         ACK_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] readWord,
    output logic       byteReceived,
    output logic       busy,
    output logic       startDetected,
    output logic       stopDetected
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ACK,
        S_IGNORE
    } state_t;

    state_t     state;
    logic       scl_meta, scl_s, scl_d;
    logic       sda_meta, sda_s, sda_d;
    logic [2:0] bit_cnt;
    logic [6:0] shift_reg;
    logic       ack_second;
    logic       sda_low;

    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic       byte_done, addr_match;
    logic [7:0] next_shift;

    assign SDA = sda_low ? 1'b0 : 1'bz;

    // Sync flops reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            scl_d    <= 1'b1;
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_meta <= SCL;
            scl_s    <= scl_meta;
            scl_d    <= scl_s;
            sda_meta <= SDA;
            sda_s    <= sda_meta;
            sda_d    <= sda_s;
        end
    end

    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_done  = (bit_cnt == 3'd7);
    assign next_shift = {shift_reg, sda_s};
    assign addr_match = (next_shift[7:1] == ADDRESS) && !next_shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            sda_low       <= 1'b0;
            readWord      <= 8'h00;
            byteReceived  <= 1'b0;
            busy          <= 1'b0;
            startDetected <= 1'b0;
            stopDetected  <= 1'b0;
            bit_cnt       <= 3'd0;
            shift_reg     <= 7'd0;
            ack_second    <= 1'b0;
        end else begin
            byteReceived  <= 1'b0;
            startDetected <= 1'b0;
            stopDetected  <= 1'b0;
            if (start_cond) begin
                if (ADDR_EN) state <= S_ADDR;
                else         state <= S_DATA;
                sda_low       <= 1'b0;
                bit_cnt       <= 3'd0;
                ack_second    <= 1'b0;
                busy          <= 1'b1;
                startDetected <= 1'b1;
            end else if (stop_cond) begin
                state        <= S_IDLE;
                sda_low      <= 1'b0;
                bit_cnt      <= 3'd0;
                ack_second   <= 1'b0;
                busy         <= 1'b0;
                stopDetected <= 1'b1;
            end else begin
                unique case (state)
                    S_ADDR, S_DATA: begin
                        if (scl_rise) begin
                            shift_reg <= next_shift[6:0];
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                if (state == S_DATA) begin
                                    readWord     <= next_shift;
                                    byteReceived <= 1'b1;
                                    state        <= S_ACK;
                                end else if (addr_match) begin
                                    state <= S_ACK;
                                end else begin
                                    state <= S_IGNORE;
                                end
                            end
                        end
                    end
                    // First fall opens the 9th clock, second fall closes it.
                    S_ACK: begin
                        if (scl_fall) begin
                            if (!ack_second) begin
                                sda_low    <= ACK_EN;
                                ack_second <= 1'b1;
                            end else begin
                                sda_low    <= 1'b0;
                                ack_second <= 1'b0;
                                bit_cnt    <= 3'd0;
                                state      <= S_DATA;
                            end
                        end
                    end
                    default: begin
                        sda_low <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_receiver.sv
// tb/tb_i2c_receiver.sv - bench for i2c_receiver: data-only and address-filtered targets on one bus
`timescale 1ns/1ps
module tb_i2c_receiver;

    localparam int PH_IDLE = 0;
    localparam int PH_ADDR = 1;
    localparam int PH_DATA = 2;
    localparam int PH_IGN  = 3;
    localparam logic [6:0] OWN_ADDR = 7'h50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic m_sda = 1'b1;
    wire  sda_bus0, sda_bus1;

    pullup (sda_bus0);
    pullup (sda_bus1);
    assign sda_bus0 = m_sda ? 1'bz : 1'b0;
    assign sda_bus1 = m_sda ? 1'bz : 1'b0;

    logic [7:0] rw [2];
    logic       br [2];
    logic       bz [2];
    logic       sd [2];
    logic       pd [2];

    i2c_receiver #(.ADDR_EN(1'b0), .ADDRESS(7'h50), .ACK_EN(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .SCL(scl), .SDA(sda_bus0),
        .readWord(rw[0]), .byteReceived(br[0]), .busy(bz[0]),
        .startDetected(sd[0]), .stopDetected(pd[0])
    );

    i2c_receiver #(.ADDR_EN(1'b1), .ADDRESS(7'h50), .ACK_EN(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .SCL(scl), .SDA(sda_bus1),
        .readWord(rw[1]), .byteReceived(br[1]), .busy(bz[1]),
        .startDetected(sd[1]), .stopDetected(pd[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected observable events, keyed by cycle*2 + target index.
    bit         ev_strb  [int];
    logic [7:0] ev_word  [int];
    bit         ev_start [int];
    bit         ev_stop  [int];
    bit         ev_busy  [int];
    bit         ev_ack   [int];
    int         rst_cycle = -1;

    bit         addr_en [2] = '{1'b0, 1'b1};
    int         ph      [2] = '{PH_IDLE, PH_IDLE};
    int         cnt     [2] = '{0, 0};
    int         ack_stg [2] = '{0, 0};
    logic [7:0] sh      [2] = '{8'h00, 8'h00};

    logic [7:0] exp_word [2] = '{8'h00, 8'h00};
    bit         exp_busy [2] = '{1'b0, 1'b0};
    bit         exp_ack  [2] = '{1'b0, 1'b0};

    int n_checks = 0;
    int n_err    = 0;
    int obs_strb [2] = '{0, 0};
    int obs_start[2] = '{0, 0};
    int obs_stop [2] = '{0, 0};

    function automatic int key(int c, int d);
        return c * 2 + d;
    endfunction

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
        end
    endtask

    logic sda_now;
    int   k;
    always @(negedge clk) begin
        if (cyc == rst_cycle) begin
            for (int d = 0; d < 2; d++) begin
                exp_word[d] = 8'h00;
                exp_busy[d] = 1'b0;
                exp_ack[d]  = 1'b0;
            end
        end
        for (int d = 0; d < 2; d++) begin
            k = key(cyc, d);
            if (ev_strb.exists(k)) exp_word[d] = ev_word[k];
            if (ev_busy.exists(k)) exp_busy[d] = ev_busy[k];
            if (ev_ack.exists(k))  exp_ack[d]  = ev_ack[k];
            sda_now = (d == 0) ? sda_bus0 : sda_bus1;
            if (br[d] === 1'b1) obs_strb[d]++;
            if (sd[d] === 1'b1) obs_start[d]++;
            if (pd[d] === 1'b1) obs_stop[d]++;
            check("byteReceived",  d, br[d], ev_strb.exists(k));
            check("readWord",      d, rw[d], exp_word[d]);
            check("startDetected", d, sd[d], ev_start.exists(k));
            check("stopDetected",  d, pd[d], ev_stop.exists(k));
            check("busy",          d, bz[d], exp_busy[d]);
            check("sda_bus",       d, sda_now, m_sda & ~exp_ack[d]);
        end
    end

    task automatic on_start();
        for (int d = 0; d < 2; d++) begin
            ev_start[key(cyc + 3, d)] = 1'b1;
            ev_busy[key(cyc + 3, d)]  = 1'b1;
            ev_ack[key(cyc + 3, d)]   = 1'b0;
            ph[d]      = addr_en[d] ? PH_ADDR : PH_DATA;
            cnt[d]     = 0;
            ack_stg[d] = 0;
        end
    endtask

    task automatic on_stop();
        for (int d = 0; d < 2; d++) begin
            ev_stop[key(cyc + 3, d)] = 1'b1;
            ev_busy[key(cyc + 3, d)] = 1'b0;
            ev_ack[key(cyc + 3, d)]  = 1'b0;
            ph[d]      = PH_IDLE;
            cnt[d]     = 0;
            ack_stg[d] = 0;
        end
    endtask

    task automatic on_rise(bit b);
        for (int d = 0; d < 2; d++) begin
            if (ack_stg[d] != 0 || !(ph[d] == PH_ADDR || ph[d] == PH_DATA)) continue;
            sh[d] = {sh[d][6:0], b};
            cnt[d]++;
            if (cnt[d] == 8) begin
                cnt[d] = 0;
                if (ph[d] == PH_DATA) begin
                    ev_strb[key(cyc + 3, d)] = 1'b1;
                    ev_word[key(cyc + 3, d)] = sh[d];
                    ack_stg[d] = 1;
                end else if (sh[d][7:1] == OWN_ADDR && !sh[d][0]) begin
                    ack_stg[d] = 1;
                    ph[d]      = PH_DATA;
                end else begin
                    ph[d] = PH_IGN;
                end
            end
        end
    endtask

    task automatic on_fall();
        for (int d = 0; d < 2; d++) begin
            if (ack_stg[d] == 1) begin
                ev_ack[key(cyc + 3, d)] = 1'b1;
                ack_stg[d] = 2;
            end else if (ack_stg[d] == 2) begin
                ev_ack[key(cyc + 3, d)] = 1'b0;
                ack_stg[d] = 0;
            end
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_scl(bit v);
        if (v && !scl) begin
            scl = 1'b1;
            on_rise(m_sda);
        end else if (!v && scl) begin
            scl = 1'b0;
            on_fall();
        end
    endtask

    task automatic send_start();
        m_sda = 1'b1;
        tick(3);
        set_scl(1'b1);
        tick(3);
        m_sda = 1'b0;
        on_start();
        tick(3);
        set_scl(1'b0);
        tick(3);
    endtask

    task automatic send_stop();
        m_sda = 1'b0;
        tick(3);
        set_scl(1'b1);
        tick(3);
        m_sda = 1'b1;
        on_stop();
        tick(6);
    endtask

    task automatic send_bit(bit b);
        m_sda = b;
        tick(3);
        set_scl(1'b1);
        tick(4);
        set_scl(1'b0);
        tick(2);
    endtask

    task automatic send_bits(logic [7:0] v, int n);
        for (int i = 0; i < n; i++) send_bit(v[7 - i]);
    endtask

    task automatic send_byte(logic [7:0] v);
        send_bits(v, 8);
        send_bit(1'b1);
    endtask

    task automatic model_reset();
        ev_strb.delete();
        ev_word.delete();
        ev_start.delete();
        ev_stop.delete();
        ev_busy.delete();
        ev_ack.delete();
        rst_cycle = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            ph[d]      = PH_IDLE;
            cnt[d]     = 0;
            ack_stg[d] = 0;
        end
    endtask

    int s_strb [2];
    int s_start[2];
    int s_stop [2];

    task automatic snap();
        for (int d = 0; d < 2; d++) begin
            s_strb[d]  = obs_strb[d];
            s_start[d] = obs_start[d];
            s_stop[d]  = obs_stop[d];
        end
    endtask

    initial begin
        tick(2);
        model_reset();
        tick(3);
        rst = 1'b0;
        tick(5);

        // Data-only target takes both bytes; filtered target sees A5 as a foreign address.
        snap();
        send_start();
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_stop();
        check("s1_strobes", 0, obs_strb[0] - s_strb[0], 2);
        check("s1_word",    0, rw[0], 8'h3C);
        check("s1_starts",  0, obs_start[0] - s_start[0], 1);
        check("s1_stops",   0, obs_stop[0] - s_stop[0], 1);
        check("s1_strobes", 1, obs_strb[1] - s_strb[1], 0);
        check("s1_busy",    0, bz[0], 0);

        snap();
        send_start();
        send_byte(8'hA0);
        send_byte(8'h12);
        send_stop();
        check("s2_strobes", 1, obs_strb[1] - s_strb[1], 1);
        check("s2_word",    1, rw[1], 8'h12);
        check("s2_strobes", 0, obs_strb[0] - s_strb[0], 2);

        snap();
        send_start();
        send_byte(8'hA2);
        send_byte(8'h77);
        send_stop();
        check("s3_strobes", 1, obs_strb[1] - s_strb[1], 0);
        check("s3_word",    1, rw[1], 8'h12);
        check("s3_word",    0, rw[0], 8'h77);

        // Repeated START after four bits abandons the partial byte.
        snap();
        send_start();
        send_bits(8'hB6, 4);
        send_start();
        send_byte(8'hF0);
        send_stop();
        check("s4_strobes", 0, obs_strb[0] - s_strb[0], 1);
        check("s4_word",    0, rw[0], 8'hF0);
        check("s4_starts",  0, obs_start[0] - s_start[0], 2);

        snap();
        send_start();
        send_bits(8'h9C, 5);
        send_stop();
        check("s5_strobes", 0, obs_strb[0] - s_strb[0], 0);
        check("s5_strobes", 1, obs_strb[1] - s_strb[1], 0);
        check("s5_busy",    0, bz[0], 0);
        check("s5_busy",    1, bz[1], 0);

        for (int f = 0; f < 15; f++) begin
            int nb;
            send_start();
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nb; j++) begin
                if ($urandom_range(0, 5) == 0) begin
                    send_bits(8'($urandom), $urandom_range(1, 7));
                    send_start();
                end else if (j == 0 && $urandom_range(0, 1) == 1) begin
                    send_byte(8'hA0);
                end else begin
                    send_byte(8'($urandom));
                end
            end
            send_stop();
        end

        // Reset while both targets hold the ACK low during the 9th SCL-high phase.
        send_start();
        send_bits(8'hA0, 8);
        m_sda = 1'b1;
        tick(3);
        set_scl(1'b1);
        tick(2);
        check("ack_low_pre_rst", 0, sda_bus0, 0);
        check("ack_low_pre_rst", 1, sda_bus1, 0);
        rst = 1'b1;
        model_reset();
        tick(1);
        check("rst_sda", 0, sda_bus0, 1);
        check("rst_sda", 1, sda_bus1, 1);
        check("rst_word", 0, rw[0], 8'h00);
        check("rst_busy", 1, bz[1], 0);
        tick(3);
        rst = 1'b0;
        tick(5);

        snap();
        send_start();
        send_byte(8'hA0);
        send_byte(8'h5A);
        send_stop();
        check("post_rst_word", 1, rw[1], 8'h5A);
        check("post_rst_strobes", 0, obs_strb[0] - s_strb[0], 2);

        tick(10);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
